// File: rtl/ldl_cdc_hand_sched.sv
// Round-robin scheduler sharing one CDC handshake tx channel among N
// requesters, with programmable inter-launch gap and optional abort timer.
//
// Ports:
//   clk, rst      : tx-domain clock, synchronous active-high reset
//   req           : per-requester level request
//   req_data      : requester i word at [i*DW +: DW]
//   interval      : idle-gap length, sampled when a transfer ends
//   ch_ack        : channel completion pulse
//   gnt           : one-hot grant pulse in the first SEND cycle
//   ch_valid      : launch request to the channel
//   ch_data       : {tag, data}, frozen while ch_valid is high
//   busy          : scheduler not idle
//   timeout       : one-cycle pulse after an aborted transfer
module ldl_cdc_hand_sched #(
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int IW  = $clog2(N),
  parameter int CW  = 8,
  parameter int TW  = 16,
  parameter int TMO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   req_data,
  input  logic [CW-1:0]     interval,
  input  logic              ch_ack,
  output logic [N-1:0]      gnt,
  output logic              ch_valid,
  output logic [IW+DW-1:0]  ch_data,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam bit TMO_EN = (TMO != 0);

  // Abort fires at the end of the cycle in which the counter holds
  // TMO-1, so ch_valid stays high exactly TMO cycles.
  localparam logic [TW-1:0] TMO_LIM =
    TW'((TMO > 0) ? TMO - 1 : 0);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      gap_q, gap_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [IW+DW-1:0]   data_q, data_d;
  logic               tmo_q, tmo_d;

  logic [DW-1:0]      rd [N];
  logic               hit;
  logic [IW-1:0]      win;
  logic               tmo_hit;
  logic               done;

  // Unpack the flat data bus.
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign rd[g] = req_data[g*DW +: DW];
  end

  // Round-robin pick: first set request at or above ptr, wrapping.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      logic [IW-1:0] sel;
      idx = int'(ptr_q) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = IW'(idx);
      if (!hit && req[sel]) begin
        hit = 1'b1;
        win = sel;
      end
    end
  end

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LIM);
  assign done    = ch_ack || tmo_hit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gnt_d   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    tmo_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_SEND;
          gnt_d   = N'(1) << win;
          valid_d = 1'b1;
          data_d  = {win, rd[win]};
          cnt_d   = '0;
          if (win == IW'(N - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + IW'(1);
          end
        end
      end

      S_SEND: begin
        if (done) begin
          valid_d = 1'b0;
          // An ack in the limit cycle counts as a normal completion.
          tmo_d   = !ch_ack;
          if (interval == '0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = interval;
            state_d = S_GAP;
          end
        end else if (TMO_EN) begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_q <= CW'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt      = gnt_q;
  assign ch_valid = valid_q;
  assign ch_data  = data_q;
  assign busy     = (state_q != S_IDLE);
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_ldl_cdc_hand_sched.sv
// Bench for ldl_cdc_hand_sched: directed vector table, corner sequences
// and a random run checked against a transfer-level reference model.
module tb_ldl_cdc_hand_sched;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int CW  = 8;
  localparam int TW  = 16;
  localparam int TMO = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [CW-1:0]     interval = '0;
  logic              ch_ack = 1'b0;
  logic [N-1:0]      gnt;
  logic              ch_valid;
  logic [IW+DW-1:0]  ch_data;
  logic              busy;
  logic              timeout;

  int checks = 0;
  int failures = 0;

  ldl_cdc_hand_sched #(
    .N(N), .DW(DW), .IW(IW), .CW(CW), .TW(TW), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .interval(interval), .ch_ack(ch_ack), .gnt(gnt),
    .ch_valid(ch_valid), .ch_data(ch_data), .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks one transfer in flight, its age, the
  // remaining gap cycles and the round-robin start point.
  bit               m_active = 1'b0;
  int               m_age = 0;
  int               m_hold = 0;
  int               m_ptr = 0;
  logic [N-1:0]     e_gnt = '0;
  logic             e_valid = 1'b0;
  logic             e_to = 1'b0;
  logic [IW+DW-1:0] e_data = '0;

  task automatic model_step();
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_hold = 0; m_ptr = 0;
      e_gnt = '0; e_valid = 1'b0; e_to = 1'b0; e_data = '0;
    end else begin
      e_gnt = '0;
      e_to = 1'b0;
      if (m_active) begin
        if (ch_ack || m_age == TMO) begin
          e_to = !ch_ack;
          m_active = 1'b0;
          e_valid = 1'b0;
          m_hold = int'(interval);
        end else begin
          m_age++;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        for (int k = 0; k < N; k++) begin
          int w;
          logic [31:0] wv;
          w = (m_ptr + k) % N;
          if (req[w]) begin
            wv = w;
            m_active = 1'b1;
            m_age = 1;
            e_valid = 1'b1;
            e_gnt[w] = 1'b1;
            e_data = {wv[IW-1:0], req_data[w*DW +: DW]};
            m_ptr = (w + 1) % N;
            break;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model", {gnt, ch_valid, ch_data,
                    busy, timeout},
          {e_gnt, e_valid, e_data,
           (m_active || m_hold > 0), e_to});
      model_step();
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       vld;
    logic [9:0] dat;
    logic       bsy;
  } row_t;

  function automatic row_t mk(logic r, logic [3:0] q, logic a,
                              logic [3:0] g, logic v,
                              logic [9:0] d, logic b);
    row_t t;
    t.rst = r; t.req = q; t.ack = a;
    t.gnt = g; t.vld = v; t.dat = d; t.bsy = b;
    return t;
  endfunction

  row_t tbl [12];

  task automatic drain();
    int n;
    n = 0;
    req = '0;
    ch_ack = 1'b1;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    ch_ack = 1'b0;
    chk("drain_idle", busy, 1'b0);
  endtask

  task automatic wait_launch(input string nm);
    int n;
    n = 0;
    while (!ch_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, ch_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int lo;

    tbl[0]  = mk(1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 10'h000, 1'b0);
    tbl[1]  = mk(1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 10'h000, 1'b0);
    tbl[2]  = mk(1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 10'h0A0, 1'b1);
    tbl[3]  = mk(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 10'h0A0, 1'b0);
    tbl[4]  = mk(1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 10'h1A1, 1'b1);
    tbl[5]  = mk(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 10'h1A1, 1'b0);
    tbl[6]  = mk(1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 10'h2A2, 1'b1);
    tbl[7]  = mk(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 10'h2A2, 1'b0);
    tbl[8]  = mk(1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 10'h3A3, 1'b1);
    tbl[9]  = mk(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 10'h3A3, 1'b0);
    tbl[10] = mk(1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 10'h0A0, 1'b1);
    tbl[11] = mk(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 10'h0A0, 1'b0);

    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    interval = '0;
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      ch_ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_vld", i), ch_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_dat", i), ch_data, tbl[i].dat);
      chk($sformatf("tbl%0d_bsy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_tmo", i), timeout, 1'b0);
    end
    ch_ack = 1'b0;
    req = '0;
    tick();

    // Single requester 2, ack in third valid cycle, gap of 6.
    req_data[2*DW +: DW] = 8'hA5;
    interval = 8'd6;
    req = 4'b0100;
    wait_launch("A_launch");
    chk("A_gnt", gnt, 4'b0100);
    hi = 1;
    while (ch_valid && hi < 20) begin
      chk("A_data", ch_data, 10'h2A5);
      if (hi == 3) ch_ack = 1'b1;
      tick();
      ch_ack = 1'b0;
      if (ch_valid) hi++;
    end
    chk("A_high_len", hi, 3);
    lo = 0;
    while (!ch_valid && lo < 30) begin
      lo++;
      tick();
    end
    chk("A_low_len", lo, 7);
    chk("A_regnt", gnt, 4'b0100);
    drain();

    // Back-to-back from requester 1 with no gap.
    interval = '0;
    req = 4'b0010;
    ch_ack = 1'b1;
    wait_launch("B_launch");
    chk("B_gnt0", gnt, 4'b0010);
    for (int t = 0; t < 2; t++) begin
      tick();
      chk("B_low", ch_valid, 1'b0);
      chk("B_nognt", gnt, 4'b0000);
      tick();
      chk("B_relaunch", ch_valid, 1'b1);
      chk("B_gnt", gnt, 4'b0010);
    end
    drain();

    // Timeout abort, then the next requester after interval+1.
    interval = 8'd2;
    req = 4'b0001;
    wait_launch("C_launch");
    chk("C_gnt", gnt, 4'b0001);
    req = 4'b0010;
    hi = 1;
    while (ch_valid && hi < 30) begin
      tick();
      if (ch_valid) hi++;
    end
    chk("C_high_len", hi, TMO);
    chk("C_pulse", timeout, 1'b1);
    lo = 1;
    tick();
    chk("C_pulse_once", timeout, 1'b0);
    while (!ch_valid && lo < 30) begin
      lo++;
      tick();
    end
    chk("C_low_len", lo, 3);
    chk("C_next_gnt", gnt, 4'b0010);
    chk("C_next_tag", ch_data[9:8], 2'd1);
    drain();

    // Ack on the limit cycle, then a spurious ack during the gap.
    interval = 8'd3;
    req = 4'b0001;
    wait_launch("D_launch");
    hi = 1;
    while (ch_valid && hi < 30) begin
      if (hi == TMO) ch_ack = 1'b1;
      tick();
      ch_ack = 1'b0;
      if (ch_valid) hi++;
    end
    chk("D_high_len", hi, TMO);
    chk("D_no_pulse", timeout, 1'b0);
    lo = 0;
    while (!ch_valid && lo < 30) begin
      lo++;
      ch_ack = (lo == 2);
      tick();
    end
    ch_ack = 1'b0;
    chk("D_low_len", lo, 4);
    drain();

    // Reset in SEND cycle 2 restores req[0] priority.
    interval = '0;
    req = 4'b0010;
    wait_launch("E_launch");
    chk("E_gnt", gnt, 4'b0010);
    tick();
    chk("E_send2", ch_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E_rst_vld", ch_valid, 1'b0);
    chk("E_rst_tmo", timeout, 1'b0);
    chk("E_rst_dat", ch_data, 10'h000);
    req = 4'b1001;
    tick();
    chk("E_prio", gnt, 4'b0001);
    chk("E_tag", ch_data[9:8], 2'd0);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom);
      req_data = $urandom;
      interval = CW'($urandom_range(0, 3));
      ch_ack = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldl_cdc_hand_sched.md
# ldl_cdc_hand_sched

Transmit-side scheduler that shares one CDC handshake channel (`LDL_cdc_hand_v1`-style tx port) between N requesters in the tx clock domain. It arbitrates round-robin and captures the winner's word, tagged with the requester index. It holds the channel valid until the channel acknowledges, then enforces a programmable idle gap before the next launch. An optional timeout aborts transfers the rx side never acknowledges.

## Interface
Parameters:
- `N`, 4: number of requesters, ≥2
- `DW`, 8: data width per requester
- `IW`, $clog2(N): tag width
- `CW`, 8: interval counter width
- `TW`, 16: timeout counter width
- `TMO`, 0: timeout in cycles, 0 = disabled, must fit in TW bits

Ports:
- `clk`  in  1: single clock (tx domain)
- `rst`  in  1: synchronous, active-high reset
- `req`  in  N: request per requester, level, held until granted
- `req_data`  in  N*DW: requester i word at bits [i*DW +: DW]
- `interval`  in  CW: idle-gap length in cycles, sampled on ack/abort
- `ch_ack`  in  1: channel completion pulse
- `gnt`  out  N: one-hot, one-cycle grant pulse; data captured
- `ch_valid`  out  1: launch request to channel
- `ch_data`  out  IW+DW: {tag, data}, stable while ch_valid=1
- `busy`  out  1: state ≠ IDLE
- `timeout`  out  1: one-cycle pulse on abort

## Operation
- State machine: IDLE, SEND, GAP.
- IDLE, any req=1 at edge:
  - pick winner w, the first set bit scanning from ptr upward with wraparound.
  - Registered next cycle: gnt[w]=1, ch_valid=1, ch_data={w, req_data[w]}.
  - ptr←(w+1) mod N. State SEND, timeout counter cleared.
- IDLE, req=0: remain; all outputs low except ch_data, which holds its last value.
- SEND:
  - ch_valid=1; ch_data frozen; further req changes ignored.
  - ch_ack=1 at edge: ch_valid←0. Then:
    - interval=0: go to IDLE.
    - else: load gap counter←interval, go to GAP.
- SEND, TMO≠0, counter reaches TMO-1 with ch_ack=0: abort. timeout pulse, ch_valid←0, same interval rule as ack. No retry; data is lost.
- ch_ack and timeout limit in same cycle: ack wins, no timeout pulse.
- GAP: decrement each cycle; at count 1 go to IDLE. ch_valid=0.
- ch_ack in IDLE/GAP: ignored.
- Requester dropping req before gnt: legal, no grant issued for it.
- Reset value of all outputs is 0, with state IDLE, ptr=0 (req[0] highest priority), and counters 0.
- Reset mid-SEND drops ch_valid next cycle without a timeout pulse.

## Timing
- Request-to-launch latency is 1 cycle: req sampled at edge t; gnt/ch_valid high in cycle t+1.
- gnt is high only in the first SEND cycle.
- Ack sampled at edge e; ch_valid low from e.
- ch_valid low for exactly interval+1 cycles between back-to-back transfers: interval cycles of GAP plus 1 IDLE arbitration cycle.
- Timeout abort: ch_valid high exactly TMO cycles.
- Throughput with continuous requests and an ack k cycles after launch: one transfer per k+interval+1 cycles.
- Fairness: with all N requesting, grant order w, w+1, …, wrapping; no requester waits more than N-1 transfers.

## Test plan
- Reset with req=4'b1111 held: gnt=0 and ch_valid=0 throughout. After release, the grant sequence is 0,1,2,3,0, and ch_data tag matches gnt index each time.
- Single requester 2, req_data[2]=8'hA5, ack 3 cycles after launch, interval=6:
  - ch_data=10'h2A5 held 3 cycles.
  - ch_valid low exactly 7 cycles before the next launch.
- interval=0 back-to-back from requester 1:
  - ch_valid low exactly 1 cycle between transfers.
  - gnt[1] one pulse per transfer.
- TMO=10, ch_ack never asserted: ch_valid high 10 cycles, then timeout pulse one cycle, and the next requester is served after interval+1 cycles.
- ch_ack on the exact timeout cycle: no timeout pulse, normal completion. A spurious ch_ack during GAP causes no state change.
- rst asserted in SEND cycle 2: ch_valid=0 next cycle, ptr back to 0, and req[0] wins over req[3] afterwards.
